// File: rtl/axis_read_arbiter.sv
// axis_read_arbiter: two-requester round-robin arbiter in front of one AXI read path.
// A command (address, beat length) from either requester is handed to the read
// address generator and the read data unit. The returned beats are then steered
// to the owner until the full length has been delivered.
// Latency: 1 cycle from the req handshake to addr_valid/data_valid. After the last
// beat, the design spends 1 DONE cycle, then returns to IDLE where a new command
// can be accepted. This leaves one dead cycle between commands.
// Backpressure: up_ready follows the owner's outN_ready in ISSUE and STREAM. In
// IDLE and DONE it is 0.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   reqN_*               command inputs (address, length, valid/ready), N = 0/1
//   addr_*               command to the read address generator
//   data_*               length config to the read data unit
//   up_*                 beat stream from the read data unit (up_valid = post-pop strobe)
//   outN_*               beat stream to requester N
//   grant, busy          current owner index and command-in-progress flag
module axis_read_arbiter #(
  parameter int CONFIG_AWIDTH = 32,
  parameter int CONFIG_DWIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CONFIG_AWIDTH-1:0] req0_address,
  input  logic [CONFIG_DWIDTH-1:0] req0_length,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [CONFIG_AWIDTH-1:0] req1_address,
  input  logic [CONFIG_DWIDTH-1:0] req1_length,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  output logic [CONFIG_AWIDTH-1:0] addr_address,
  output logic [CONFIG_DWIDTH-1:0] addr_length,
  output logic                     addr_valid,
  input  logic                     addr_ready,
  output logic [CONFIG_DWIDTH-1:0] data_length,
  output logic                     data_valid,
  input  logic                     data_ready,
  input  logic [DATA_WIDTH-1:0]    up_data,
  input  logic                     up_valid,
  output logic                     up_ready,
  output logic [DATA_WIDTH-1:0]    out0_data,
  output logic                     out0_valid,
  input  logic                     out0_ready,
  output logic [DATA_WIDTH-1:0]    out1_data,
  output logic                     out1_valid,
  input  logic                     out1_ready,
  output logic                     grant,
  output logic                     busy
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_ISSUE  = 4'b0010,
    S_STREAM = 4'b0100,
    S_DONE   = 4'b1000
  } state_t;

  localparam logic [CONFIG_DWIDTH-1:0] LEN_ZERO = '0;
  localparam logic [CONFIG_DWIDTH-1:0] LEN_ONE  = {{(CONFIG_DWIDTH-1){1'b0}}, 1'b1};

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CONFIG_AWIDTH-1:0] r_addr;
  logic [CONFIG_DWIDTH-1:0] r_len;
  logic [CONFIG_DWIDTH-1:0] r_cnt;
  logic                     r_grant;
  logic                     r_last_grant;
  logic                     r_busy;
  logic                     r_addr_done;
  logic                     r_data_done;

  logic w_idle;
  logic w_issue;
  logic w_stream;
  logic w_route;
  logic w_sel0;
  logic w_sel1;
  logic w_take;
  logic w_take_len0;
  logic w_addr_fire;
  logic w_data_fire;
  logic w_cfg_done;
  logic w_beat;
  logic w_last;
  logic w_out_rdy;

  assign w_idle   = (r_state == S_IDLE);
  assign w_issue  = (r_state == S_ISSUE);
  assign w_stream = (r_state == S_STREAM);
  // Beats are accepted from the first ISSUE cycle on, because the data unit may
  // begin returning data before both config handshakes are seen here.
  assign w_route  = w_issue | w_stream;

  // Round robin: on a tie the requester that did not own the last command wins.
  // When rst_n is low, both ready outputs are held at 0, so no command is
  // consumed while the reset is being applied.
  assign w_sel0 = rst_n & req0_valid & (~req1_valid | r_last_grant);
  assign w_sel1 = rst_n & req1_valid & (~req0_valid | ~r_last_grant);
  assign w_take = w_idle & (w_sel0 | w_sel1);
  assign w_take_len0 = w_sel0 ? (req0_length == LEN_ZERO) : (req1_length == LEN_ZERO);

  assign w_addr_fire = addr_valid & addr_ready;
  assign w_data_fire = data_valid & data_ready;
  // Covers the case where both flags are already set. It also covers the case
  // where the last outstanding handshake completes in this cycle.
  assign w_cfg_done  = (r_addr_done | w_addr_fire) & (r_data_done | w_data_fire);

  assign w_out_rdy = r_grant ? out1_ready : out0_ready;
  assign w_beat    = w_route & up_valid;
  assign w_last    = w_beat & (r_cnt == (r_len - LEN_ONE));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_state_nxt = w_take_len0 ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_cfg_done) begin
          w_state_nxt = w_last ? S_DONE : S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_busy       <= 1'b0;
      r_addr_done  <= 1'b0;
      r_data_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_addr      <= w_sel0 ? req0_address : req1_address;
        r_len       <= w_sel0 ? req0_length  : req1_length;
        r_grant     <= w_sel1;
        r_busy      <= 1'b1;
        r_cnt       <= '0;
        r_addr_done <= 1'b0;
        r_data_done <= 1'b0;
      end
      if (w_issue && w_addr_fire) begin
        r_addr_done <= 1'b1;
      end
      if (w_issue && w_data_fire) begin
        r_data_done <= 1'b1;
      end
      if (w_beat) begin
        r_cnt <= r_cnt + LEN_ONE;
      end
      if (r_state == S_DONE) begin
        r_last_grant <= r_grant;
        r_busy       <= 1'b0;
      end
    end
  end

  assign req0_ready   = w_idle & w_sel0;
  assign req1_ready   = w_idle & w_sel1;

  assign addr_address = r_addr;
  assign addr_length  = r_len;
  assign addr_valid   = w_issue & ~r_addr_done;
  assign data_length  = r_len;
  assign data_valid   = w_issue & ~r_data_done;

  assign up_ready     = w_route & w_out_rdy;
  assign out0_data    = up_data;
  assign out1_data    = up_data;
  assign out0_valid   = w_route & ~r_grant & up_valid;
  assign out1_valid   = w_route &  r_grant & up_valid;

  assign grant        = r_grant;
  assign busy         = r_busy;

endmodule

// File: tb/tb_axis_read_arbiter.sv
module tb_axis_read_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] req0_address, req0_length, req1_address, req1_length;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] addr_address, addr_length, data_length;
  logic        addr_valid, addr_ready, data_valid, data_ready;
  logic [31:0] up_data, out0_data, out1_data;
  logic        up_valid, up_ready, out0_valid, out0_ready, out1_valid, out1_ready;
  logic        grant, busy;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  logic [63:0] cmd_q[$];
  logic [31:0] dlen_q[$];
  logic [63:0] m_cmd;

  axis_read_arbiter #(.CONFIG_AWIDTH(32), .CONFIG_DWIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_address(req0_address), .req0_length(req0_length),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_address(req1_address), .req1_length(req1_length),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .addr_address(addr_address), .addr_length(addr_length),
    .addr_valid(addr_valid), .addr_ready(addr_ready),
    .data_length(data_length), .data_valid(data_valid), .data_ready(data_ready),
    .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every routed beat and every downstream command is popped and compared.
  always @(negedge clk) begin
    if (rst_n) begin
      if (up_valid) begin
        chk("beat routed", {63'd0, out0_valid | out1_valid}, 64'd1);
        chk("single out valid", {63'd0, out0_valid & out1_valid}, 64'd0);
      end
      if (out0_valid) begin
        chk("out0 owner", {63'd0, grant}, 64'd0);
        if (exp0_q.size() == 0) chk("out0 unexpected beat", {63'd0, out0_valid}, 64'd0);
        else chk("out0 data", {32'd0, out0_data}, {32'd0, exp0_q.pop_front()});
      end
      if (out1_valid) begin
        chk("out1 owner", {63'd0, grant}, 64'd1);
        if (exp1_q.size() == 0) chk("out1 unexpected beat", {63'd0, out1_valid}, 64'd0);
        else chk("out1 data", {32'd0, out1_data}, {32'd0, exp1_q.pop_front()});
      end
      if (addr_valid && addr_ready) begin
        if (cmd_q.size() == 0) chk("addr unexpected cmd", {63'd0, addr_valid}, 64'd0);
        else begin
          m_cmd = cmd_q.pop_front();
          chk("addr_address", {32'd0, addr_address}, {32'd0, m_cmd[63:32]});
          chk("addr_length", {32'd0, addr_length}, {32'd0, m_cmd[31:0]});
        end
      end
      if (data_valid && data_ready) begin
        if (dlen_q.size() == 0) chk("data unexpected cfg", {63'd0, data_valid}, 64'd0);
        else chk("data_length", {32'd0, data_length}, {32'd0, dlen_q.pop_front()});
      end
    end
  end

  task automatic push_cmd(input logic [31:0] a, input logic [31:0] l);
    if (l != 0) begin
      cmd_q.push_back({a, l});
      dlen_q.push_back(l);
    end
  endtask

  // Drives one command from requester r alone and waits (bounded) for its ready.
  task automatic send_cmd(input bit r, input logic [31:0] a, input logic [31:0] l);
    bit ok = 1'b0;
    @(posedge clk); #1;
    if (r) begin req1_address = a; req1_length = l; req1_valid = 1'b1; end
    else   begin req0_address = a; req0_length = l; req0_valid = 1'b1; end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (r ? req1_ready : req0_ready) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("req accepted", {63'd0, ok}, 64'd1);
    chk("other req idle", {63'd0, r ? req0_ready : req1_ready}, 64'd0);
    push_cmd(a, l);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Data-unit model: a beat strobe follows each cycle where up_ready was seen high.
  task automatic run_beats(input bit r, input int n, input bit toggle);
    int sent = 0;
    int cyc = 0;
    bit pop = 1'b0;
    while (sent < n && cyc < 200) begin
      @(posedge clk); #1;
      up_valid = pop;
      if (pop) begin
        up_data = $urandom;
        if (r) exp1_q.push_back(up_data);
        else   exp0_q.push_back(up_data);
        sent++;
      end
      if (toggle) begin
        if (r) out1_ready = ~cyc[0];
        else   out0_ready = ~cyc[0];
      end
      @(negedge clk);
      chk("up_ready mirror", {63'd0, up_ready}, {63'd0, r ? out1_ready : out0_ready});
      pop = up_ready && (sent < n);
      cyc++;
    end
    if (sent < n) chk("beat timeout", 64'(sent), 64'(n));
    @(posedge clk); #1;
    up_valid = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
  endtask

  // Called right after the last beat: one DONE cycle, then IDLE.
  task automatic finish_cmd();
    @(negedge clk);
    chk("busy in DONE", {63'd0, busy}, 64'd1);
    chk("up_ready in DONE", {63'd0, up_ready}, 64'd0);
    @(negedge clk);
    chk("busy after DONE", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    addr_ready = 1'b1; data_ready = 1'b1;
    out0_ready = 1'b1; out1_ready = 1'b1;
    up_valid = 1'b0; up_data = '0;
    req0_address = 32'h100; req0_length = 32'd2; req0_valid = 1'b1;
    req1_address = 32'h200; req1_length = 32'd2; req1_valid = 1'b1;

    // Reset with both requesters already waiting.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst addr_valid", {63'd0, addr_valid}, 64'd0);
    chk("rst data_valid", {63'd0, data_valid}, 64'd0);
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst req0_ready", {63'd0, req0_ready}, 64'd0);
    chk("rst req1_ready", {63'd0, req1_ready}, 64'd0);
    chk("rst up_ready", {63'd0, up_ready}, 64'd0);

    // Tie after reset: requester 0 wins, then requester 1, then requester 0 again.
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("tie1 req0_ready", {63'd0, req0_ready}, 64'd1);
    chk("tie1 req1_ready", {63'd0, req1_ready}, 64'd0);
    push_cmd(32'h100, 32'd2);
    @(posedge clk); #1; req0_valid = 1'b0;
    @(negedge clk);
    chk("tie1 grant", {63'd0, grant}, 64'd0);
    chk("tie1 busy", {63'd0, busy}, 64'd1);
    run_beats(1'b0, 2, 1'b0);
    @(negedge clk);
    chk("no accept in DONE", {63'd0, req1_ready}, 64'd0);
    @(negedge clk);
    chk("tie2 req1_ready", {63'd0, req1_ready}, 64'd1);
    push_cmd(32'h200, 32'd2);
    @(posedge clk); #1; req1_valid = 1'b0;
    @(negedge clk);
    chk("tie2 grant", {63'd0, grant}, 64'd1);
    run_beats(1'b1, 2, 1'b0);
    finish_cmd();
    @(posedge clk); #1;
    req0_address = 32'h300; req0_length = 32'd1; req0_valid = 1'b1;
    req1_address = 32'h400; req1_length = 32'd1; req1_valid = 1'b1;
    @(negedge clk);
    chk("tie3 req0_ready", {63'd0, req0_ready}, 64'd1);
    chk("tie3 req1_ready", {63'd0, req1_ready}, 64'd0);
    push_cmd(32'h300, 32'd1);
    @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0;
    run_beats(1'b0, 1, 1'b0);
    finish_cmd();

    // Single req0 at 0x1000, 4 beats.
    send_cmd(1'b0, 32'h1000, 32'd4);
    @(negedge clk);
    chk("t1 addr_valid", {63'd0, addr_valid}, 64'd1);
    chk("t1 data_valid", {63'd0, data_valid}, 64'd1);
    chk("t1 addr_address", {32'd0, addr_address}, 64'h1000);
    chk("t1 data_length", {32'd0, data_length}, 64'd4);
    @(negedge clk);
    chk("t1 addr_valid drop", {63'd0, addr_valid}, 64'd0);
    chk("t1 data_valid drop", {63'd0, data_valid}, 64'd0);
    run_beats(1'b0, 4, 1'b0);
    finish_cmd();

    // data_ready delayed by 5 cycles, addr_ready immediate.
    data_ready = 1'b0;
    send_cmd(1'b0, 32'h2000, 32'd3);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) data_ready = 1'b1;
      @(negedge clk);
      chk("t3 data_valid held", {63'd0, data_valid}, 64'd1);
      chk("t3 addr_valid", {63'd0, addr_valid}, {63'd0, i == 0});
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("t3 data_valid drop", {63'd0, data_valid}, 64'd0);
    run_beats(1'b0, 3, 1'b0);
    finish_cmd();

    // Zero-length command from requester 1: nothing is issued downstream.
    send_cmd(1'b1, 32'h5000, 32'd0);
    @(negedge clk);
    chk("t4 addr_valid", {63'd0, addr_valid}, 64'd0);
    chk("t4 data_valid", {63'd0, data_valid}, 64'd0);
    chk("t4 busy in DONE", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("t4 busy after", {63'd0, busy}, 64'd0);

    // last_grant is now 1, so requester 0 wins the tie; then req1 does 8 beats
    // with out1_ready toggling.
    @(posedge clk); #1;
    req0_address = 32'h6000; req0_length = 32'd1; req0_valid = 1'b1;
    req1_address = 32'h7000; req1_length = 32'd8; req1_valid = 1'b1;
    @(negedge clk);
    chk("t5 req0_ready", {63'd0, req0_ready}, 64'd1);
    chk("t5 req1_ready", {63'd0, req1_ready}, 64'd0);
    push_cmd(32'h6000, 32'd1);
    @(posedge clk); #1; req0_valid = 1'b0;
    run_beats(1'b0, 1, 1'b0);
    finish_cmd();
    chk("t5 req1 granted", {63'd0, req1_ready}, 64'd1);
    push_cmd(32'h7000, 32'd8);
    @(posedge clk); #1; req1_valid = 1'b0;
    run_beats(1'b1, 8, 1'b1);
    finish_cmd();
    chk("t5 out1 beats left", 64'(exp1_q.size()), 64'd0);

    // Reset in STREAM after 2 of 6 beats; the next command starts from count 0.
    send_cmd(1'b0, 32'h8000, 32'd6);
    run_beats(1'b0, 2, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("t6 busy", {63'd0, busy}, 64'd0);
    chk("t6 addr_valid", {63'd0, addr_valid}, 64'd0);
    chk("t6 up_ready", {63'd0, up_ready}, 64'd0);
    exp0_q.delete(); exp1_q.delete(); cmd_q.delete(); dlen_q.delete();
    send_cmd(1'b0, 32'h9000, 32'd3);
    run_beats(1'b0, 3, 1'b0);
    finish_cmd();

    chk("end out0 queue", 64'(exp0_q.size()), 64'd0);
    chk("end out1 queue", 64'(exp1_q.size()), 64'd0);
    chk("end cmd queue", 64'(cmd_q.size()), 64'd0);
    chk("end dlen queue", 64'(dlen_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
